sram_responder: RTL and testbench
=================================

Name: sram_responder

Overview:
- Synthesizable responder for the external-SRAM pin interface: sram_a[20:0], bidirectional sram_d[7:0], sram_we_n.
- Used in place of the physical chip to self-check the SRAM test initiator on-board and in simulation.
- Models an asynchronous-read, end-of-pulse-write SRAM backed by an internal distributed-RAM array.
- Adds protocol checking, a write counter and single-bit fault injection, so the initiator's fail path can be exercised.

Parameters:
- AW, 10: internal array address width. Depth is 2**AW bytes, mirrored across the full 21-bit space.
- MAXWLOW, 8: maximum legal consecutive clocks with sram_we_n low before a protocol error is flagged.
- CNTW, 16: width of the write-commit counter.

Ports:
- clk  in  1  system clock, shared with the initiator.
- rst_n  in  1  reset; synchronous, active-low.
- sram_a  in  21  address from the initiator.
- sram_d  inout  8  data bus. Driven by the responder only when resp_en=1 and sram_we_n=1; high-Z otherwise.
- sram_we_n  in  1  write strobe, active-low.
- resp_en  in  1  enables the read drive onto sram_d.
- fault_en  in  1  enables fault injection on reads.
- fault_addr  in  AW  array index whose read data is corrupted.
- fault_bit  in  3  bit position that is forced.
- fault_val  in  1  forced value (0 = stuck-at-0, 1 = stuck-at-1).
- write_count  out  CNTW  number of committed writes; saturating.
- range_err  out  1  sticky: a write committed with sram_a[20:AW] != 0.
- proto_err  out  1  sticky: protocol violation during a write pulse.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - write_count=0, range_err=0, proto_err=0.
  - FSM to IDLE; any pending write is discarded and not committed.
  - Array contents are untouched and undefined at power-up.
  - sram_d read drive still follows resp_en/sram_we_n combinationally during reset.
- Read path:
  - Combinational. rdata = mem[sram_a[AW-1:0]], zero latency, so data is valid in the same cycle the address is presented.
  - If fault_en=1 and sram_a[AW-1:0]==fault_addr, bit fault_bit of rdata is replaced by fault_val.
  - Fault injection applies to reads only; stored contents are never modified by it.
- Write FSM, states IDLE, WLOW:
  - IDLE: on a clk edge with sram_we_n=0, latch waddr=sram_a, wdata=sram_d, set lowcnt=1, go to WLOW.
  - WLOW, sram_we_n=0:
    - Re-latch wdata=sram_d every cycle; the last value before the rising edge wins.
    - If sram_a != waddr, set proto_err.
    - lowcnt increments and saturates at MAXWLOW+1. When lowcnt reaches MAXWLOW+1, set proto_err. The write is still committed on release.
  - WLOW, sram_we_n=1 (end of pulse):
    - Commit mem[waddr[AW-1:0]] <= wdata.
    - write_count += 1, saturating at all-ones.
    - If waddr[20:AW] != 0, set range_err.
    - Return to IDLE.
  - Commit timing: a one-cycle low pulse (low at edge N, high at edge N+1) commits at edge N+1. A read of that address is valid combinationally from the cycle after edge N+1.
  - Back-to-back pulses: a pulse may begin at the edge immediately after a commit edge (IDLE sees we_n=0). A one-cycle high gap is sufficient.
- Read during an uncommitted write returns the old array contents; there is no bypass.
- Sticky flags clear only on reset.

Decomposition:
- Shared package sram_pkg:
  - Constants SRAM_AW_EXT=21 and SRAM_DW=8.
  - State encodings IDLE=1'b0 and WLOW=1'b1.
  - Test pattern constants PAT_A=8'h55 and PAT_SUM=8'hAA, shared with the initiator so both ends agree.
- Sub-module sram_resp_array: AW-wide distributed RAM with async read and one synchronous write port.
- Top module contains the FSM, checks, counter, fault mux and tristate.

Test Plan:
- Reset with rst_n=0 for 2 clocks, then release -> write_count=0, range_err=0, proto_err=0, sram_d high-Z while sram_we_n=0.
- One-cycle write of 8'h55 to address 21'h000003, then set sram_a=3 with we_n high -> sram_d=8'h55 the cycle after the commit edge; write_count=1.
- Full initiator sequence over 2**AW addresses (write 55, read-add-write AA, verify) -> every read returns 8'hAA; write_count=2048 for AW=10; no error flags set.
- fault_en=1, fault_addr=5, fault_bit=7, fault_val=0; location 5 holds 8'hAA -> reading address 5 returns 8'h2A; address 6 still returns 8'hAA.
- Write to 21'h000400 with AW=10 -> range_err=1, and data aliases to index 0. Also hold we_n low for 9 clocks -> proto_err=1, write still committed.
- Change sram_a mid-pulse, then assert rst_n=0 before the rising edge of we_n -> no commit, write_count unchanged at 0, proto_err cleared by reset.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared constants for the external-SRAM pin interface, used by both the
// responder and the test initiator so that both ends agree on widths and patterns.
package sram_pkg;
   localparam int SRAM_AW_EXT = 21;
   localparam int SRAM_DW     = 8;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] WLOW = 1'b1;

   localparam logic [SRAM_DW-1:0] PAT_A   = 8'h55;
   localparam logic [SRAM_DW-1:0] PAT_SUM = 8'hAA;
endpackage

// File: rtl/sram_responder_if.sv
// Initiator-side SRAM pins plus the responder's test controls. The bidirectional
// data bus stays a plain inout on the responder so the tristate resolves on a net.
interface sram_responder_if #(parameter int AW = 10);
   import sram_pkg::*;

   logic [SRAM_AW_EXT-1:0] sram_a;
   logic                   sram_we_n;
   logic                   resp_en;
   logic                   fault_en;
   logic [AW-1:0]          fault_addr;
   logic [2:0]             fault_bit;
   logic                   fault_val;

   modport master (
      output sram_a, sram_we_n, resp_en, fault_en, fault_addr, fault_bit, fault_val
   );

   modport slave (
      input  sram_a, sram_we_n, resp_en, fault_en, fault_addr, fault_bit, fault_val
   );
endinterface

// File: rtl/sram_resp_array.sv
// Distributed-RAM backing store: asynchronous read, one synchronous write port.
// No reset on purpose; contents survive rst_n and are undefined at power-up.
module sram_resp_array #(
   parameter int AW = 10,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);
   logic [DW-1:0] mem [2**AW];

   // single synchronous write port
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/sram_responder.sv
// Stand-in for the external SRAM: end-of-pulse write FSM with protocol checks,
// a saturating commit counter and read-side single-bit fault injection.
module sram_responder
   import sram_pkg::*;
#(
   parameter int AW      = 10,
   parameter int MAXWLOW = 8,
   parameter int CNTW    = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   sram_responder_if.slave     bus,
   inout  wire  [SRAM_DW-1:0]  sram_d,
   output logic [CNTW-1:0]     write_count,
   output logic                range_err,
   output logic                proto_err
);
   localparam int              LCW    = $clog2(MAXWLOW + 2);
   localparam logic [LCW-1:0]  LC_MAX = LCW'(MAXWLOW + 1);

   logic [0:0]             state;
   logic [SRAM_AW_EXT-1:0] waddr;
   logic [SRAM_DW-1:0]     wdata;
   logic [LCW-1:0]         lowcnt;
   logic                   commit;
   logic [SRAM_DW-1:0]     rdata;
   logic [SRAM_DW-1:0]     rdata_f;

   sram_resp_array #(.AW(AW), .DW(SRAM_DW)) u_array (
      .clk   (clk),
      .we    (commit),
      .waddr (waddr[AW-1:0]),
      .wdata (wdata),
      .raddr (bus.sram_a[AW-1:0]),
      .rdata (rdata)
   );

   // a reset edge wins over a pending release, so the write is dropped
   always_comb begin
      commit = 1'b0;
      if (rst_n && (state == WLOW) && bus.sram_we_n) begin
         commit = 1'b1;
      end else begin
         commit = 1'b0;
      end
   end

   // fault only alters what is returned, never what is stored
   always_comb begin
      rdata_f = rdata;
      if (bus.fault_en && (bus.sram_a[AW-1:0] == bus.fault_addr)) begin
         rdata_f[bus.fault_bit] = bus.fault_val;
      end else begin
         rdata_f = rdata;
      end
   end

   assign sram_d = (bus.resp_en && bus.sram_we_n) ? rdata_f : {SRAM_DW{1'bz}};

   // write-pulse FSM, commit counter and sticky checks
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         waddr       <= '0;
         wdata       <= '0;
         lowcnt      <= '0;
         write_count <= '0;
         range_err   <= 1'b0;
         proto_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!bus.sram_we_n) begin
                  waddr  <= bus.sram_a;
                  wdata  <= sram_d;
                  lowcnt <= LCW'(1);
                  state  <= WLOW;
               end
            end
            WLOW: begin
               if (!bus.sram_we_n) begin
                  wdata <= sram_d;
                  if (bus.sram_a != waddr) begin
                     proto_err <= 1'b1;
                  end
                  if (lowcnt != LC_MAX) begin
                     lowcnt <= lowcnt + LCW'(1);
                     if ((lowcnt + LCW'(1)) == LC_MAX) begin
                        proto_err <= 1'b1;
                     end
                  end
               end else begin
                  if (write_count != {CNTW{1'b1}}) begin
                     write_count <= write_count + CNTW'(1);
                  end
                  if (|waddr[SRAM_AW_EXT-1:AW]) begin
                     range_err <= 1'b1;
                  end
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: a per-cycle compare process against a
// transaction-level model, directed scenarios with literal expectations, then random traffic.
module tb_sram_responder;
   import sram_pkg::*;

   localparam int AW      = 10;
   localparam int DEPTH   = 1 << AW;
   localparam int MAXWLOW = 8;
   localparam int CNTW    = 16;
   localparam int CNTMAX  = (1 << CNTW) - 1;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   wire  [7:0]      sram_d;
   logic            tb_drv = 1'b0;
   logic [7:0]      tb_data = 8'h00;
   logic [CNTW-1:0] write_count;
   logic            range_err;
   logic            proto_err;

   sram_responder_if #(.AW(AW)) bus();

   sram_responder #(.AW(AW), .MAXWLOW(MAXWLOW), .CNTW(CNTW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .sram_d      (sram_d),
      .write_count (write_count),
      .range_err   (range_err),
      .proto_err   (proto_err)
   );

   assign sram_d = tb_drv ? tb_data : 8'hzz;

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   bit   chk_on = 1'b0;

   // transaction-level model of what the pins must show
   logic [7:0] mem_m   [DEPTH];
   bit         valid_m [DEPTH];
   int         cnt_m   = 0;
   bit         range_m = 1'b0;
   bit         proto_m = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] exp_rd(input logic [AW-1:0] idx);
      logic [7:0] v;
      v = mem_m[idx];
      if (bus.fault_en && (idx == bus.fault_addr)) v[bus.fault_bit] = bus.fault_val;
      return v;
   endfunction

   function automatic int exp_cnt();
      return (cnt_m > CNTMAX) ? CNTMAX : cnt_m;
   endfunction

   // continuous comparison of every observable output against the model
   always @(negedge clk) begin
      if (chk_on) begin
         check("write_count", 32'(write_count), 32'(exp_cnt()));
         check("range_err", 32'(range_err), 32'(range_m));
         check("proto_err", 32'(proto_err), 32'(proto_m));
         if (tb_drv) begin
            check("bus_release", 32'(sram_d), 32'(tb_data));
         end else if (bus.resp_en && bus.sram_we_n && valid_m[bus.sram_a[AW-1:0]]) begin
            check("read_data", 32'(sram_d), 32'(exp_rd(bus.sram_a[AW-1:0])));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int cycles);
      rst_n = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         cnt_m   = 0;
         range_m = 1'b0;
         proto_m = 1'b0;
         chk_on  = 1'b1;
      end
      rst_n = 1'b1;
   endtask

   task automatic rd(input logic [20:0] a, output logic [7:0] v);
      bus.sram_a    = a;
      bus.sram_we_n = 1'b1;
      bus.resp_en   = 1'b1;
      @(negedge clk);
      v = sram_d;
      tick();
   endtask

   // low for len edges; vary changes data each cycle, move shifts the address after edge 1
   task automatic write_pulse(input logic [20:0] a, input logic [7:0] d, input int len,
                              input bit vary, input bit move);
      logic [7:0] last;
      bit         moved;
      last  = d;
      moved = 1'b0;
      bus.sram_a    = a;
      bus.sram_we_n = 1'b0;
      tb_data       = d;
      tb_drv        = 1'b1;
      for (int k = 1; k <= len; k++) begin
         tick();
         if (moved || (k >= MAXWLOW + 1)) proto_m = 1'b1;
         if (k < len) begin
            if (vary) begin
               last    = 8'($urandom);
               tb_data = last;
            end
            if (move && (k == 1)) begin
               bus.sram_a = a ^ 21'h000001;
               moved      = 1'b1;
            end
         end
      end
      bus.sram_we_n = 1'b1;
      tb_drv        = 1'b0;
      tick();
      mem_m[a[AW-1:0]]   = last;
      valid_m[a[AW-1:0]] = 1'b1;
      cnt_m++;
      if (a[20:AW] != '0) range_m = 1'b1;
   endtask

   initial begin
      logic [7:0]  v;
      int          bad;
      logic [20:0] ra;
      int          len;

      bus.sram_a     = '0;
      bus.sram_we_n  = 1'b0;
      bus.resp_en    = 1'b1;
      bus.fault_en   = 1'b0;
      bus.fault_addr = '0;
      bus.fault_bit  = 3'd0;
      bus.fault_val  = 1'b0;
      tb_drv         = 1'b1;
      tb_data        = 8'h5A;
      for (int i = 0; i < DEPTH; i++) valid_m[i] = 1'b0;

      // reset with the strobe low: responder must not drive the bus
      do_reset(2);
      bus.sram_we_n = 1'b1;
      tb_drv        = 1'b0;
      tick();
      check("rst_write_count", 32'(write_count), 32'd0);
      check("rst_range_err", 32'(range_err), 32'd0);
      check("rst_proto_err", 32'(proto_err), 32'd0);

      // single one-cycle write, read back the cycle after commit
      write_pulse(21'h000003, PAT_A, 1, 1'b0, 1'b0);
      rd(21'h000003, v);
      check("wr55_read", 32'(v), 32'h55);
      check("wr55_count", 32'(write_count), 32'd1);

      // full initiator sequence
      do_reset(2);
      for (int a = 0; a < DEPTH; a++) write_pulse(21'(a), PAT_A, 1, 1'b0, 1'b0);
      for (int a = 0; a < DEPTH; a++) begin
         rd(21'(a), v);
         write_pulse(21'(a), v + PAT_A, 1, 1'b0, 1'b0);
      end
      bad = 0;
      for (int a = 0; a < DEPTH; a++) begin
         rd(21'(a), v);
         if (v !== PAT_SUM) bad++;
      end
      check("seq_bad_reads", 32'(bad), 32'd0);
      check("seq_count", 32'(write_count), 32'd2048);
      check("seq_range_err", 32'(range_err), 32'd0);
      check("seq_proto_err", 32'(proto_err), 32'd0);

      // stuck-at-0 on bit 7 of location 5
      bus.fault_en   = 1'b1;
      bus.fault_addr = 10'd5;
      bus.fault_bit  = 3'd7;
      bus.fault_val  = 1'b0;
      rd(21'h000005, v);
      check("fault_addr5", 32'(v), 32'h2A);
      rd(21'h000006, v);
      check("fault_addr6", 32'(v), 32'hAA);
      bus.fault_en = 1'b0;
      rd(21'h000005, v);
      check("fault_off_addr5", 32'(v), 32'hAA);

      // long pulses: 8 lows is legal, 9 lows flags but still commits
      do_reset(2);
      write_pulse(21'h000007, 8'h11, MAXWLOW, 1'b0, 1'b0);
      check("low8_proto", 32'(proto_err), 32'd0);
      write_pulse(21'h000008, 8'h22, MAXWLOW + 1, 1'b0, 1'b0);
      check("low9_proto", 32'(proto_err), 32'd1);
      rd(21'h000008, v);
      check("low9_commit", 32'(v), 32'h22);
      write_pulse(21'h000400, 8'h3C, 1, 1'b0, 1'b0);
      check("range_flag", 32'(range_err), 32'd1);
      rd(21'h000000, v);
      check("range_alias", 32'(v), 32'h3C);
      check("range_count", 32'(write_count), 32'd3);

      // address moves mid-pulse, then reset lands before release
      do_reset(2);
      tick();
      bus.sram_a    = 21'h000009;
      bus.sram_we_n = 1'b0;
      tb_data       = 8'h77;
      tb_drv        = 1'b1;
      tick();
      bus.sram_a = 21'h00000A;
      tick();
      proto_m = 1'b1;
      check("kill_proto_set", 32'(proto_err), 32'd1);
      rst_n = 1'b0;
      tick();
      cnt_m   = 0;
      range_m = 1'b0;
      proto_m = 1'b0;
      bus.sram_we_n = 1'b1;
      tb_drv        = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      check("kill_count", 32'(write_count), 32'd0);
      check("kill_proto_clr", 32'(proto_err), 32'd0);
      rd(21'h000009, v);
      check("kill_no_commit", 32'(v), 32'hAA);

      // random traffic against the model
      for (int n = 0; n < 600; n++) begin
         case ($urandom_range(0, 39))
            0: begin
               bus.sram_we_n = 1'b1;
               tb_drv        = 1'b0;
               do_reset(1 + $urandom_range(0, 1));
            end
            default: begin
               if ($urandom_range(0, 1) == 0) begin
                  ra = 21'($urandom_range(0, DEPTH - 1));
                  if ($urandom_range(0, 7) == 0) ra = 21'($urandom);
                  len = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 10) : $urandom_range(1, 3);
                  write_pulse(ra, 8'($urandom), len, 1'b1,
                              (len > 1) && ($urandom_range(0, 9) == 0));
               end else begin
                  bus.fault_en   = ($urandom_range(0, 2) == 0);
                  bus.fault_addr = 10'($urandom_range(0, 15));
                  bus.fault_bit  = 3'($urandom);
                  bus.fault_val  = 1'($urandom);
                  bus.resp_en    = ($urandom_range(0, 5) != 0);
                  bus.sram_a     = 21'($urandom_range(0, 15));
                  bus.sram_we_n  = 1'b1;
                  tick();
               end
            end
         endcase
      end

      bus.fault_en = 1'b0;
      bus.resp_en  = 1'b1;
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
